// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: mul/div op codes, mul/div FSM encoding
// and the fixed result constants of the mul/div unit.
package mips_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    // LO value written for any divide by zero (HI keeps the original dividend)
    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath on a 2*WIDTH accumulator:
// shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] rem_sh_s;
    logic [WIDTH:0] diff_s;

    // Multiply: {partial, multiplier} shifts right with carry.
    // Divide: {remainder, dividend} shifts left, quotient bits enter at the bottom.
    always_comb begin
        sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        rem_sh_s = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, opnd};
        if (is_div) begin
            if (!diff_s[WIDTH]) begin
                acc_next = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum_s, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Operates on magnitudes for WIDTH steps, then applies signs in a final FIX cycle.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    md_state_t          state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opnd_r;
    logic [WIDTH-1:0]   a_orig_r;
    logic               is_div_r;
    logic               neg_res_r;
    logic               neg_rem_r;
    logic               dz_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               is_div_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   hi_res_s;
    logic [WIDTH-1:0]   lo_res_s;

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Operand decode: op type and operand magnitudes for the signed ops
    always_comb begin
        is_div_s = (op == OP_DIV) || (op == OP_DIVU);
        a_neg_s  = ((op == OP_MULT) || (op == OP_DIV)) && a[WIDTH-1];
        b_neg_s  = ((op == OP_MULT) || (op == OP_DIV)) && b[WIDTH-1];
        a_mag_s  = a_neg_s ? (~a + WIDTH'(1)) : a;
        b_mag_s  = b_neg_s ? (~b + WIDTH'(1)) : b;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_r),
        .acc      (acc_r),
        .opnd     (opnd_r),
        .acc_next (acc_next_s)
    );

    // Sign fix-up and final HI/LO selection, consumed in the FIX state
    always_comb begin
        if (neg_res_r) begin
            prod_s = ~acc_r + (2*WIDTH)'(1);
            quo_s  = ~acc_r[WIDTH-1:0] + WIDTH'(1);
        end else begin
            prod_s = acc_r;
            quo_s  = acc_r[WIDTH-1:0];
        end
        if (neg_rem_r) begin
            rem_s = ~acc_r[2*WIDTH-1:WIDTH] + WIDTH'(1);
        end else begin
            rem_s = acc_r[2*WIDTH-1:WIDTH];
        end
        if (!is_div_r) begin
            hi_res_s = prod_s[2*WIDTH-1:WIDTH];
            lo_res_s = prod_s[WIDTH-1:0];
        end else if (dz_r) begin
            hi_res_s = a_orig_r;
            lo_res_s = WIDTH'(DIV_ZERO_LO);
        end else begin
            hi_res_s = rem_s;
            lo_res_s = quo_s;
        end
    end

    // Control FSM with counter, operand latches and HI/LO registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            a_orig_r  <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            dz_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (hi_we) hi_r <= wdata;
                    if (lo_we) lo_r <= wdata;
                    if (start) begin
                        // Multiplier or dividend sits in the low half; the other operand is held aside
                        acc_r     <= {{WIDTH{1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
                        opnd_r    <= is_div_s ? b_mag_s : a_mag_s;
                        a_orig_r  <= a;
                        is_div_r  <= is_div_s;
                        neg_res_r <= a_neg_s ^ b_neg_s;
                        neg_rem_r <= a_neg_s;
                        dz_r      <= is_div_s && (b == {WIDTH{1'b0}});
                        cnt_r     <= {CNT_W{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) state_r <= ST_FIX;
                end
                ST_FIX: begin
                    hi_r    <= hi_res_s;
                    lo_r    <= lo_res_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
